// File: rtl/mem_pkg.sv
// Shared definitions for the load/store sequencer: size codes, FSM states and
// the alignment rule.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLresp,
        StMerge,
        StWrite,
        StErr
    } state_t;

    // True when the byte offset cannot host an access of this size.
    function automatic logic misaligned(input logic [1:0] offset, input logic [1:0] size);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane steering: extracts/extends a load lane and merges store
// data into a read word. Purely combinational.
module lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sext,
    output logic [31:0] ext_data,
    output logic [31:0] merge_data
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] mask;

    // Extract the addressed lane and extend it; offset is aligned for halves.
    always_comb begin
        shamt   = {offset, 3'b000};
        shifted = word >> shamt;
        case (size)
            SZ_BYTE: ext_data = {{24{sext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: ext_data = {{16{sext & shifted[15]}}, shifted[15:0]};
            default: ext_data = word;
        endcase
    end

    // Replace the target lane(s) of the read word with right-aligned store data.
    always_comb begin
        case (size)
            SZ_BYTE: mask = 32'h0000_00ff << shamt;
            SZ_HALF: mask = 32'h0000_ffff << shamt;
            default: mask = 32'hffff_ffff;
        endcase
        merge_data = (word & ~mask) | ((wdata << shamt) & mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the word-addressed data memory. Sub-word
// stores are done as read-modify-write; loads are lane-selected and extended.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [29:0] dm_ad,
    output logic [31:0] dm_wrdata,
    output logic        dm_wr,
    input  logic [31:0] dm_rd
);

    state_t      state;
    logic [31:0] addr_l;
    logic        we_l;
    logic [1:0]  size_l;
    logic        sext_l;
    logic [31:0] wdata_l;

    logic [31:0] ext_data;
    logic [31:0] merge_data;

    // One aligner serves both the load-extract and the store-merge path; in
    // both cases the source word is the one dm returned after the READ edge.
    lane_align u_lane_align (
        .word       (dm_rd),
        .wdata      (wdata_l),
        .offset     (addr_l[1:0]),
        .size       (size_l),
        .sext       (sext_l),
        .ext_data   (ext_data),
        .merge_data (merge_data)
    );

    // Sequencer: latches the request and walks READ/MERGE/WRITE/LRESP/ERR.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= StIdle;
            addr_l  <= '0;
            we_l    <= 1'b0;
            size_l  <= SZ_BYTE;
            sext_l  <= 1'b0;
            wdata_l <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                StIdle: begin
                    if (req) begin
                        addr_l  <= addr;
                        we_l    <= we;
                        size_l  <= size;
                        sext_l  <= sext;
                        wdata_l <= wdata;
                        if (misaligned(addr[1:0], size)) begin
                            state <= StErr;
                        end else if (!we || size != SZ_WORD) begin
                            state <= StRead;
                        end else begin
                            state <= StWrite;
                        end
                    end
                end
                StRead:  state <= we_l ? StMerge : StLresp;
                StLresp: begin
                    rdata <= ext_data;
                    done  <= 1'b1;
                    state <= StIdle;
                end
                StMerge, StWrite: begin
                    done  <= 1'b1;
                    state <= StIdle;
                end
                StErr: begin
                    err   <= 1'b1;
                    done  <= 1'b1;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Memory port drive decoded from state so an async reset drops dm_wr at once.
    always_comb begin
        ready     = (state == StIdle);
        dm_ad     = addr_l[31:2];
        dm_wr     = 1'b0;
        dm_wrdata = '0;
        case (state)
            StMerge: begin
                dm_wr     = 1'b1;
                dm_wrdata = merge_data;
            end
            StWrite: begin
                dm_wr     = 1'b1;
                dm_wrdata = wdata_l;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural dm model.
module tb_mem_access_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [29:0] dm_ad;
    logic [31:0] dm_wrdata;
    logic        dm_wr;
    logic [31:0] dm_rd;

    mem_access_unit dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req       (req),
        .we        (we),
        .size      (size),
        .sext      (sext),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .dm_ad     (dm_ad),
        .dm_wrdata (dm_wrdata),
        .dm_wr     (dm_wr),
        .dm_rd     (dm_rd)
    );

    always #5 Clk = ~Clk;

    // dm model: write when dm_wr, otherwise register the addressed word.
    logic [31:0] mem [0:15];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;
    always @(posedge Clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (dm_wr) mem[dm_ad[3:0]] <= dm_wrdata;
        if (!dm_wr) dm_rd <= mem[dm_ad[3:0]];
    end

    int wr_total = 0;
    int done_total = 0;
    always @(negedge Clk) begin
        if (dm_wr) wr_total <= wr_total + 1;
        if (done) done_total <= done_total + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
        logic [31:0] exp_word;
    } vec_t;
    vec_t vq[$];

    function automatic vec_t mk(input string n, input logic w, input logic [1:0] s,
                                input logic x, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] i, input logic [31:0] r, input logic e,
                                input int l, input int nw, input logic [31:0] ew);
        vec_t v;
        v.name = n; v.we = w; v.size = s; v.sext = x; v.addr = a; v.wdata = d;
        v.init = i; v.exp_rdata = r; v.exp_err = e; v.exp_lat = l; v.exp_wr = nw;
        v.exp_word = ew;
        return v;
    endfunction

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        @(negedge Clk);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(posedge Clk);
        #1 pl_en = 1'b0;
    endtask

    // Drive a request at a negedge; returns #1 after the accepting edge.
    task automatic issue(input logic w, input logic [1:0] s, input logic x,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge Clk);
        req = 1'b1; we = w; size = s; sext = x; addr = a; wdata = d;
        @(posedge Clk);
        #1 req = 1'b0;
    endtask

    // Wait (bounded) for done; lat = edges after accept, 99 on timeout.
    task automatic wait_done(output int lat);
        lat = 99;
        for (int n = 1; n <= 8; n++) begin
            @(posedge Clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic pop_check(input string name);
        sb_t e;
        if (sbq.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sbq.pop_front();
        chk({name, "_err"}, {31'd0, err}, {31'd0, e.err});
        if (e.chk_rd) chk({name, "_rdata"}, rdata, e.rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int w0;
        int d0;
        sb_t e;
        vec_t v;

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        Reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
        addr = '0; wdata = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_dm_wr", {31'd0, dm_wr}, 32'd0);
        chk("rst_dm_ad", {2'b00, dm_ad}, 32'd0);
        chk("rst_dm_wrdata", dm_wrdata, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // name, we, size, sext, addr, wdata, init, rdata, err, lat, writes, final word
        vq.push_back(mk("ldb_s_lane2", 0, 2'b00, 1, 32'h0E, 0, 32'h80FF7F01, 32'hFFFFFFFF, 0, 2, 0, 32'h80FF7F01));
        vq.push_back(mk("ldb_z_lane2", 0, 2'b00, 0, 32'h0E, 0, 32'h80FF7F01, 32'h000000FF, 0, 2, 0, 32'h80FF7F01));
        vq.push_back(mk("ldb_s_lane0", 0, 2'b00, 1, 32'h0C, 0, 32'h80FF7F01, 32'h00000001, 0, 2, 0, 32'h80FF7F01));
        vq.push_back(mk("ldb_s_lane1", 0, 2'b00, 1, 32'h0D, 0, 32'h80FF7F01, 32'h0000007F, 0, 2, 0, 32'h80FF7F01));
        vq.push_back(mk("ldb_s_lane3", 0, 2'b00, 1, 32'h0F, 0, 32'h80FF7F01, 32'hFFFFFF80, 0, 2, 0, 32'h80FF7F01));
        vq.push_back(mk("ldh_s_hi", 0, 2'b01, 1, 32'h0E, 0, 32'h80FF7F01, 32'hFFFF80FF, 0, 2, 0, 32'h80FF7F01));
        vq.push_back(mk("ldh_z_lo", 0, 2'b01, 0, 32'h0C, 0, 32'h80FF7F01, 32'h00007F01, 0, 2, 0, 32'h80FF7F01));
        vq.push_back(mk("ldw", 0, 2'b10, 0, 32'h0C, 0, 32'h80FF7F01, 32'h80FF7F01, 0, 2, 0, 32'h80FF7F01));
        vq.push_back(mk("sth_hi", 1, 2'b01, 0, 32'h0E, 32'h0000BEEF, 32'h11223344, 0, 0, 2, 1, 32'hBEEF3344));
        vq.push_back(mk("stb_lane1", 1, 2'b00, 0, 32'h0D, 32'h123456AA, 32'h11223344, 0, 0, 2, 1, 32'h1122AA44));
        vq.push_back(mk("stw", 1, 2'b10, 0, 32'h14, 32'h01020304, 32'h55555555, 0, 0, 1, 1, 32'h01020304));
        vq.push_back(mk("mis_ldw", 0, 2'b10, 0, 32'h12, 0, 32'h77777777, 0, 1, 1, 0, 32'h77777777));
        vq.push_back(mk("mis_sth", 1, 2'b01, 0, 32'h01, 32'hFFFF, 32'h66666666, 0, 1, 1, 0, 32'h66666666));
        vq.push_back(mk("ill_size", 1, 2'b11, 0, 32'h0C, 32'hFFFFFFFF, 32'h44444444, 0, 1, 1, 0, 32'h44444444));

        foreach (vq[i]) begin
            v = vq[i];
            preload(v.addr[5:2], v.init);
            w0 = wr_total;
            e.err = v.exp_err;
            e.chk_rd = !v.we && !v.exp_err;
            e.rdata = v.exp_rdata;
            sbq.push_back(e);
            issue(v.we, v.size, v.sext, v.addr, v.wdata);
            wait_done(lat);
            chk({v.name, "_lat"}, lat, v.exp_lat);
            pop_check(v.name);
            chk({v.name, "_mem"}, mem[v.addr[5:2]], v.exp_word);
            chk({v.name, "_wrcnt"}, wr_total - w0, v.exp_wr);
            @(posedge Clk);
            #1 chk({v.name, "_done_1cyc"}, {31'd0, done}, 32'd0);
        end

        // Word store, then a load accepted in the cycle the store's done is high.
        preload(4'd4, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEBABE);
        e.err = 1'b0; e.chk_rd = 1'b0; e.rdata = '0;
        sbq.push_back(e);
        wait_done(lat);
        chk("b2b_st_lat", lat, 1);
        pop_check("b2b_st");
        chk("b2b_ready_on_done", {31'd0, ready}, 32'd1);
        req = 1'b1; we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h10;
        e.err = 1'b0; e.chk_rd = 1'b1; e.rdata = 32'hCAFEBABE;
        sbq.push_back(e);
        @(posedge Clk);
        #1 req = 1'b0;
        wait_done(lat);
        chk("b2b_ld_lat", lat, 2);
        pop_check("b2b_ld");

        // Request pulsed while busy must be ignored.
        preload(4'd3, 32'h11111111);
        preload(4'd8, 32'h0);
        d0 = done_total;
        issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
        chk("busy_ready_low", {31'd0, ready}, 32'd0);
        @(negedge Clk);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'hDEADDEAD;
        @(negedge Clk);
        req = 1'b0;
        repeat (6) @(posedge Clk);
        #1;
        chk("busy_done_count", done_total - d0, 1);
        chk("busy_mem_untouched", mem[8], 32'h0);
        chk("busy_rdata", rdata, 32'h11111111);

        // Reset during MERGE aborts the write and produces no done.
        preload(4'd3, 32'h11223344);
        issue(1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000BEEF);
        @(posedge Clk);
        #1 chk("merge_dm_wr_high", {31'd0, dm_wr}, 32'd1);
        #2 Reset = 1'b1;
        #1;
        chk("rstm_dm_wr", {31'd0, dm_wr}, 32'd0);
        chk("rstm_ready", {31'd0, ready}, 32'd1);
        chk("rstm_done", {31'd0, done}, 32'd0);
        d0 = done_total;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        chk("rstm_mem", mem[3], 32'h11223344);
        chk("rstm_no_done", done_total - d0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the execute stage and the word-addressed data memory `dm`. It accepts one byte, halfword or word request at a time and drives `dm`'s `Ad`/`WrData`/`DMWr` ports. Sub-word stores are built as read-modify-write sequences, and load data is extracted and sign- or zero-extended. The pipeline stalls on `ready=0` and consumes `rdata` on `done`.

## Interface
- No parameters; widths fixed at 32-bit data, 30-bit word address.
- `Clk`  in  1  clock; all state on posedge.
- `Reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  request valid; accepted only when `ready=1`.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `sext`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `ready`  out  1  unit idle, can accept.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  with `done`: misaligned/illegal request, no memory access made.
- `rdata`  out  32  extended load result; valid when `done & ~we_l & ~err`.
- `dm_ad`  out  30  to `dm.Ad` (word address = latched addr[31:2]).
- `dm_wrdata`  out  32  to `dm.WrData`.
- `dm_wr`  out  1  to `dm.DMWr`.
- `dm_rd`  in  32  from `dm.DM`; registered, updated on a posedge when `dm_wr=0`.

## Operation
- Latches `addr`, `we`, `size`, `sext`, `wdata` on acceptance (`req & ready`).
- Alignment check on latched request: half needs addr[0]=0; word needs addr[1:0]=00; size 11 always illegal.
- Little-endian lanes: byte offset k occupies bits [8k+7:8k]; half at offset 0 is [15:0], at offset 2 is [31:16].
- FSM states:
  - IDLE: `ready=1`. On accept: misaligned → ERR; load or sub-word store → READ; word store → WRITE.
  - READ: `dm_wr=0`, `dm_ad` = latched word address. `dm` captures the word this edge. Next state: load → LRESP; store → MERGE.
  - LRESP: `rdata <= extend(select(dm_rd))`, `done <= 1`. Next state IDLE.
  - MERGE: `dm_wr=1`, `dm_wrdata` = `dm_rd` with the target lane(s) replaced by `wdata`. `done <= 1`. Next state IDLE.
  - WRITE: `dm_wr=1`, `dm_wrdata` = latched `wdata`. `done <= 1`. Next state IDLE.
  - ERR: `err <= 1`, `done <= 1`, `dm_wr=0`. Next state IDLE.
- `dm_wr=0` in every state except MERGE and WRITE.
- `req` while `ready=0` is ignored; the requester holds it.

## Timing
- Reset values: state IDLE, `ready=1`, `done=0`, `err=0`, `rdata=0`, `dm_wr=0`, `dm_ad=0`, `dm_wrdata=0`, all latches 0.
- Accept at edge E0.
- Load: READ during cycle after E0, `dm` reads at E1; `done`/`rdata` high after E2. Latency 2 edges, `ready` low 2 cycles.
- Word store: write at E1, `done` after E1.
- Sub-word store: read at E1, merged write at E2, `done` after E2.
- Misaligned: `done`/`err` after E1.
- `done` and `err` last exactly one cycle; `rdata` holds until the next load completes.
- Back-to-back: a new request may be accepted in the cycle `done` is high, since the state is IDLE.
- Reset mid-operation aborts immediately: no write is issued after `Reset` rises and no `done` is produced.
- Sub-word stores are not atomic against other `dm` writers; this unit is the sole writer.

## Structure
- Shared package `mem_pkg`: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, `misaligned()` function.
- Sub-module `lane_align` (combinational): `extract(word, offset, size, sext)` and `merge(word, wdata, offset, size)`. The FSM instantiates it once and reuses it for both paths.

## Test plan
- Signed byte load: `dm` word 3 = 0x80FF7F01, load byte addr 0x0E sext=1 → `rdata`=0xFFFFFFFF... lane 2=0xFF → 0xFFFFFFFF. Same with sext=0 → 0x000000FF. Both with `done` 2 edges after accept.
- Half store RMW: word 3 = 0x11223344, store half 0xBEEF at 0x0E → word 3 = 0xBEEF3344. Exactly one `dm_wr` cycle; `done` 2 edges after accept.
- Word store then load: store 0xCAFEBABE at 0x10, immediately load word 0x10 → `rdata`=0xCAFEBABE. Store `done` 1 edge after accept.
- Misaligned: load word 0x12, store half 0x01, size=11 → each gives `done=err=1` one edge after accept, `dm_wr` never asserted, memory unchanged.
- Reset during MERGE: assert `Reset` → `dm_wr` drops at once, `ready=1`, no `done`.
- Request during busy: pulse `req` while `ready=0` → ignored, no extra `done`.
